// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: instruction fetch controller with a DEPTH-entry prefetch
// queue. Owns the fetch PC, issues one word read at a time over a req/ack
// handshake, buffers {pc, instruction} pairs and flushes on redirect.
// Optional build macro: FETCH_STALL_CNT_EN adds the stall_cnt output.
module fetch_queue_ctrl #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_addr,
  output logic                       mem_req,
  output logic [WIDTH-1:0]           mem_addr,
  input  logic                       mem_ack,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic                       instr_valid,
  output logic [WIDTH-1:0]           instr_data,
  output logic [WIDTH-1:0]           instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AL = $clog2(WIDTH / 8);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << AL) - 1);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_redir_pc;
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [WIDTH-1:0] r_q_pc   [DEPTH];
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_load_addr;

  assign w_redir_pc = redirect_addr & ~LOW_MASK;
  assign w_pop      = (r_count != '0) && instr_ready;
  // Only a live (non-discarded) response without a concurrent redirect is kept.
  assign w_push     = (r_state == S_REQ) && mem_ack && !redirect;

  // Next occupancy and next fetch PC; redirect overrides push and pop.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (redirect) begin
      w_pc_nxt = w_redir_pc;
    end else if (w_push) begin
      w_pc_nxt = r_fetch_pc + STEP;
    end else begin
      w_pc_nxt = r_fetch_pc;
    end
    w_issue = go && (w_count_nxt < CW'(DEPTH));
  end

  // Next-state logic; the issue decision uses post-update count and PC so a
  // redirect or completed ack can launch the next request on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load_addr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_REQ;
          w_load_addr = 1'b1;
        end
      end
      S_REQ, S_DISCARD: begin
        if (mem_ack) begin
          if (w_issue) begin
            w_state_nxt = S_REQ;
            w_load_addr = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect) begin
          w_state_nxt = S_DISCARD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, fetch PC and held request address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_ADDR;
      r_mem_addr <= RESET_ADDR;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      if (w_load_addr) begin
        r_mem_addr <= w_pc_nxt;
      end
    end
  end

  // Circular queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (redirect) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_push) begin
          r_q_data[r_wr] <= mem_rdata;
          r_q_pc[r_wr]   <= r_fetch_pc;
          r_wr           <= r_wr + PW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + PW'(1);
        end
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where fetch is enabled but decode has nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (go && (r_count == '0) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign mem_req     = (r_state != S_IDLE);
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr_data  = r_q_data[r_rd];
  assign instr_pc    = r_q_pc[r_rd];
  assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl (WIDTH=32, DEPTH=4, RESET_ADDR=0).
// Memory returns addr ^ 0xA5A50000; ack is gated by ack_en.
module tb_fetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;
  logic        ack_en;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  always #5 clk = ~clk;

  assign mem_ack   = ack_en & mem_req;
  assign mem_rdata = mem_addr ^ KEY;

  fetch_queue_ctrl #(
    .WIDTH      (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .count         (count)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset         = 1'b0;
    go            = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b0;
    ack_en        = 1'b0;

    // Reset held with go=1
    tick();
    chk("rst_req",   64'(mem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'h0);
    chk("rst_data",  64'(instr_data), 64'h0);
    chk("rst_pc",    64'(instr_pc), 64'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b1;
    tick();
    chk("first_req",  64'(mem_req), 64'd1);
    chk("first_addr", 64'(mem_addr), 64'h0);

    // Zero-wait streaming: one instruction per cycle
    ack_en      = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_pc",    64'(instr_pc), 64'(32'(i * 4)));
      chk("stream_data",  64'(instr_data), 64'(32'(i * 4) ^ KEY));
      chk("stream_count", 64'(count), 64'd1);
    end

    // Flush with redirect to 0, then fill without popping
    instr_ready   = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 32'h0;
    tick();
    redirect = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(instr_valid), 64'd0);
    chk("flush_addr",  64'(mem_addr), 64'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_req",   64'(mem_req), 64'd1);
    end
    tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_req",   64'(mem_req), 64'd0);
    tick();
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_hold_req",   64'(mem_req), 64'd0);
    chk("full_head_pc",    64'(instr_pc), 64'h0);

    // One pop frees a slot; next request targets 0x10
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    tick();
    instr_ready = 1'b0;
    chk("pop_count", 64'(count), 64'd3);
    chk("pop_req",   64'(mem_req), 64'd1);
    chk("pop_addr",  64'(mem_addr), 64'h10);
    chk("pop_head",  64'(instr_pc), 64'h4);

    // Redirect to 0x103 while ack is withheld
    redirect      = 1'b1;
    redirect_addr = 32'h103;
    tick();
    redirect = 1'b0;
    chk("disc_req",   64'(mem_req), 64'd1);
    chk("disc_addr",  64'(mem_addr), 64'h10);
    chk("disc_count", 64'(count), 64'd0);
    chk("disc_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("disc_hold_addr1", 64'(mem_addr), 64'h10);
    tick();
    chk("disc_hold_req",   64'(mem_req), 64'd1);
    chk("disc_hold_addr2", 64'(mem_addr), 64'h10);
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    chk("disc_drop_count", 64'(count), 64'd0);
    chk("disc_drop_valid", 64'(instr_valid), 64'd0);
    chk("redir_req",       64'(mem_req), 64'd1);
    chk("redir_addr",      64'(mem_addr), 64'h100);

    // Redirect to top of address space with zero-wait memory
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    ack_en        = 1'b1;
    instr_ready   = 1'b1;
    tick();
    redirect = 1'b0;
    chk("top_count", 64'(count), 64'd0);
    chk("top_addr",  64'(mem_addr), 64'hFFFF_FFFC);
    tick();
    chk("top_pc0",   64'(instr_pc), 64'hFFFF_FFFC);
    chk("top_data0", 64'(instr_data), 64'h5A5A_FFFC);
    tick();
    chk("wrap_pc1",   64'(instr_pc), 64'h0);
    chk("wrap_data1", 64'(instr_data), 64'hA5A5_0000);
    chk("wrap_count", 64'(count), 64'd1);

    // go=0 mid-request: outstanding ack is still pushed, no new request
    go          = 1'b0;
    instr_ready = 1'b0;
    tick();
    chk("nogo_req",   64'(mem_req), 64'd0);
    chk("nogo_count", 64'(count), 64'd2);
    tick();
    chk("nogo_hold_req", 64'(mem_req), 64'd0);

    // Re-reset, then withhold ack for the first request
    reset  = 1'b0;
    go     = 1'b1;
    ack_en = 1'b0;
    tick();
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_req",   64'(mem_req), 64'd0);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("wait_req", 64'(mem_req), 64'd1);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_run", 64'(stall_cnt), 64'(i));
`endif
    end
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    chk("late_valid", 64'(instr_valid), 64'd1);
    chk("late_pc",    64'(instr_pc), 64'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_final", 64'(stall_cnt), 64'd5);
`endif
    tick();
`ifdef FETCH_STALL_CNT_EN
    chk("stall_frozen", 64'(stall_cnt), 64'd5);
`endif
    chk("next_req",  64'(mem_req), 64'd1);
    chk("next_addr", 64'(mem_addr), 64'h4);

    // Asynchronous reset mid-request, away from any clock edge
    reset = 1'b0;
    #1;
    chk("async_req",   64'(mem_req), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_addr",  64'(mem_addr), 64'h0);
    ack_en = 1'b1;
    tick();
    chk("async_hold_valid", 64'(instr_valid), 64'd0);
    chk("async_hold_req",   64'(mem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_ctrl.md
# fetch_queue_ctrl

Parametrised instruction fetch controller with a prefetch queue, sitting between instruction memory and the decode/main controller of the CPU. It owns the fetch PC, issues word reads over a req/ack handshake, buffers up to DEPTH fetched instructions tagged with their PC, and flushes and redirects on branch/jump. It replaces the single-instruction fetch-then-wait flow with continuous, back-pressured prefetch.

## Interface
- WIDTH, 32, instruction/address width in bits; must be a multiple of 8, ≥16.
- DEPTH, 4, queue entries; power of 2, ≥2.
- RESET_ADDR, 0, fetch PC after reset; low log2(WIDTH/8) bits must be zero.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  fetch enable; 0 blocks new memory requests.
- redirect  in  1  single-cycle flush-and-jump strobe.
- redirect_addr  in  WIDTH  new fetch PC; low log2(WIDTH/8) bits are forced to 0.
- mem_req  out  1  read request.
- mem_addr  out  WIDTH  read byte address.
- mem_ack  in  1  read complete; mem_rdata valid this cycle; may assert in the same cycle mem_req is first seen.
- mem_rdata  in  WIDTH  read data.
- instr_valid  out  1  queue head valid (count≠0).
- instr_data  out  WIDTH  queue head instruction.
- instr_pc  out  WIDTH  queue head PC.
- instr_ready  in  1  decode accepts head; pop on instr_valid&instr_ready.
- count  out  log2(DEPTH)+1  queue occupancy.

## Operation
- FSM states: IDLE (mem_req=0), REQ (mem_req=1, mem_addr=fetch_pc), DISCARD (mem_req=1, response is dropped).
- IDLE→REQ when go=1 and count<DEPTH.
- REQ with mem_ack and no redirect:
  - Push {fetch_pc, mem_rdata}.
  - fetch_pc += WIDTH/8, mod 2^WIDTH.
  - Stay in REQ (back-to-back, new mem_addr) if go=1 and next count<DEPTH; else go to IDLE.
- Only one request is outstanding at a time. mem_req and mem_addr are held stable until mem_ack.
- Redirect, in any state:
  - count←0 and the queue is flushed.
  - fetch_pc←redirect_addr (aligned).
  - Redirect takes priority over a push or pop in the same cycle. A concurrent pop handshake still completes from decode's view.
- Redirect in REQ without mem_ack→DISCARD. Redirect in REQ with mem_ack→data dropped, then the normal IDLE/REQ decision is made using the new PC.
- DISCARD with mem_ack: drop data, then apply the IDLE/REQ decision. A redirect in DISCARD updates fetch_pc and stays in DISCARD.
- go=0 during REQ: the outstanding request completes and is pushed; no new request is issued.
- Full queue with simultaneous pop and push: allowed; count is unchanged.
- Queue is a circular buffer with rd/wr pointers wrapping at DEPTH.

## Timing
- Reset values:
  - state IDLE, fetch_pc=RESET_ADDR.
  - mem_req=0, mem_addr=RESET_ADDR.
  - count=0, instr_valid=0, instr_data=0, instr_pc=0.
- All outputs are registered or decoded from registers only; there is no combinational path from input to output.
- go asserted at edge N → mem_req=1 from cycle N+1.
- mem_ack in cycle M → entry visible (instr_valid=1) at cycle M+1.
- Zero-wait memory sustains 1 instruction/cycle.
- Redirect at edge R → first request for redirect_addr in cycle R+1 (from REQ/IDLE), or in the cycle after the pending ack (from DISCARD).
- Async reset mid-request: mem_req drops immediately without a clock edge; the in-flight ack is ignored.

## Configuration
- FETCH_STALL_CNT_EN defined: adds output stall_cnt [31:0].
  - Increments each cycle with go=1 and instr_valid=0.
  - Saturates at 0xFFFFFFFF; reset to 0; not cleared by redirect.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset low with go=1 → mem_req=0, instr_valid=0, count=0. After reset release → mem_req=1, mem_addr=0x0 at the next edge.
- Zero-wait memory, instr_ready=1 → instr_pc 0x0,0x4,0x8,0xC on consecutive cycles, instr_data matching memory.
- instr_ready=0, DEPTH=4 → exactly 4 acks, then mem_req=0, count=4. One pop → count 3 → request at mem_addr 0x10.
- Redirect to 0x103 while ack is delayed 3 cycles:
  - mem_req is held at the old address until ack.
  - Data is dropped and count=0.
  - Next mem_addr=0x100.
- Redirect to 0xFFFFFFFC with zero-wait memory → instr_pc 0xFFFFFFFC then 0x00000000.
- With FETCH_STALL_CNT_EN: go=1, memory withholds ack for 5 cycles after reset → stall_cnt=5 (plus the initial request cycle per definition), frozen once instr_valid=1.
